// File: rtl/bcd_digit_converter_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
// State encoding, saturation limit and digit count live here.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [15:0] MAX_BCD        = 16'd9999;
   localparam int          DIGITS         = 4;
   localparam logic [3:0]  BLANK_CODE_DEF = 4'hF;

endpackage

// File: rtl/bcd_digit_converter_if.sv
// Start/busy/done handshake plus committed digit bus of the converter.
// master drives the request, slave is the converter itself.
interface bcd_digit_converter_if #(
   parameter int BIN_W = 14
);

   logic             start;
   logic [BIN_W-1:0] bin_in;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [3:0]       Dig_1;
   logic [3:0]       Dig_2;
   logic [3:0]       Dig_3;
   logic [3:0]       Dig_4;

   modport master (
      output start, bin_in,
      input  busy, done, ovf,
      input  Dig_1, Dig_2, Dig_3, Dig_4
   );

   modport slave (
      input  start, bin_in,
      output busy, done, ovf,
      output Dig_1, Dig_2, Dig_3, Dig_4
   );

endinterface

// File: rtl/bcd_digit_converter_dd_adjust_nibble.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module dd_adjust_nibble (
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bcd_digit_converter.sv
// Iterative double-dabble converter, one shift per clock, feeding the
// four-digit seven-segment driver; digits change only at commit.
module bcd_digit_converter
   import bcd_pkg::*;
#(
   parameter int         BIN_W      = 14,
   parameter bit         BLANK_LZ   = 1'b0,
   parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
   input  logic                clk,
   input  logic                reset,
   bcd_digit_converter_if.slave bus
);

   localparam int            CW   = $clog2(BIN_W);
   localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [BIN_W-1:0] bin_q;
   logic [BIN_W-1:0] bin_d;
   logic [15:0]      bcd_q;
   logic [15:0]      bcd_d;
   logic [15:0]      bcd_adj;
   logic             ovf_pend_q;
   logic             busy_q;
   logic             done_q;
   logic             ovf_q;
   logic [15:0]      dig_q;
   logic [15:0]      dig_d;

   logic [15:0]      in_ext;
   logic [15:0]      in_sat;
   logic             in_big;

   logic             blk4;
   logic             blk3;
   logic             blk2;

   assign in_ext = 16'(bus.bin_in);
   assign in_big = (in_ext > MAX_BCD);
   assign in_sat = in_big ? MAX_BCD : in_ext;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      dd_adjust_nibble u_adj (
         .nib_i (bcd_q[4*g +: 4]),
         .nib_o (bcd_adj[4*g +: 4])
      );
   end

   assign bcd_d = {bcd_adj[14:0], bin_q[BIN_W-1]};
   assign bin_d = {bin_q[BIN_W-2:0], 1'b0};

   // Leading-zero blanking chains from the thousands digit downward.
   always_comb begin
      blk4  = BLANK_LZ && (bcd_q[15:12] == 4'd0);
      blk3  = blk4 && (bcd_q[11:8] == 4'd0);
      blk2  = blk3 && (bcd_q[7:4] == 4'd0);
      dig_d = bcd_q;
      if (blk4) dig_d[15:12] = BLANK_CODE;
      if (blk3) dig_d[11:8]  = BLANK_CODE;
      if (blk2) dig_d[7:4]   = BLANK_CODE;
   end

   // Control FSM with registered handshake and digit outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         dig_q      <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  bin_q      <= in_sat[BIN_W-1:0];
                  ovf_pend_q <= in_big;
                  bcd_q      <= '0;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_q <= bcd_d;
               bin_q <= bin_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) state_q <= COMMIT;
            end
            COMMIT: begin
               dig_q   <= dig_d;
               ovf_q   <= ovf_pend_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.ovf   = ovf_q;
   assign bus.Dig_1 = dig_q[3:0];
   assign bus.Dig_2 = dig_q[7:4];
   assign bus.Dig_3 = dig_q[11:8];
   assign bus.Dig_4 = dig_q[15:12];

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Directed bench for bcd_digit_converter: one plain and one blanking
// instance share clock and reset; expectations are hand-computed.
module tb_bcd_digit_converter;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_fail;

   bcd_digit_converter_if #(.BIN_W(14)) ifa ();
   bcd_digit_converter_if #(.BIN_W(14)) ifb ();

   bcd_digit_converter #(
      .BIN_W    (14),
      .BLANK_LZ (1'b0)
   ) u_a (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifa)
   );

   bcd_digit_converter #(
      .BIN_W      (14),
      .BLANK_LZ   (1'b1),
      .BLANK_CODE (4'hF)
   ) u_b (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic s, input int v);
      if (sel) begin
         ifb.start  = s;
         ifb.bin_in = 14'(v);
      end else begin
         ifa.start  = s;
         ifa.bin_in = 14'(v);
      end
   endtask

   task automatic get(input bit sel, output logic b, output logic d,
                      output logic o, output logic [15:0] dg);
      if (sel) begin
         b  = ifb.busy;
         d  = ifb.done;
         o  = ifb.ovf;
         dg = {ifb.Dig_4, ifb.Dig_3, ifb.Dig_2, ifb.Dig_1};
      end else begin
         b  = ifa.busy;
         d  = ifa.done;
         o  = ifa.ovf;
         dg = {ifa.Dig_4, ifa.Dig_3, ifa.Dig_2, ifa.Dig_1};
      end
   endtask

   // Waits (bounded) for done; n = edges since the accepting edge.
   task automatic wait_done(input bit sel, output int n,
                            output bit drop);
      logic b, d, o;
      logic [15:0] dg;
      n    = 0;
      drop = 1'b0;
      d    = 1'b0;
      while (!d && n < 40) begin
         @(posedge clk); #1;
         n++;
         get(sel, b, d, o, dg);
         if (!d && !b) drop = 1'b1;
      end
   endtask

   task automatic convert(input bit sel, input int v,
                          input logic [15:0] expd, input logic expo,
                          input string tag);
      logic b, d, o;
      logic [15:0] dg;
      int n;
      bit drop;
      drive(sel, 1'b1, v);
      @(posedge clk); #1;
      drive(sel, 1'b0, 0);
      get(sel, b, d, o, dg);
      chk({tag, "_busy_set"}, 32'(b), 32'd1);
      wait_done(sel, n, drop);
      get(sel, b, d, o, dg);
      chk({tag, "_latency"}, 32'(n), 32'd15);
      chk({tag, "_busy_held"}, 32'(drop), 32'd0);
      chk({tag, "_digits"}, 32'(dg), 32'(expd));
      chk({tag, "_ovf"}, 32'(o), 32'(expo));
      chk({tag, "_busy_clr"}, 32'(b), 32'd0);
      @(posedge clk); #1;
      get(sel, b, d, o, dg);
      chk({tag, "_done_pulse"}, 32'(d), 32'd0);
      chk({tag, "_hold_dig"}, 32'(dg), 32'(expd));
      chk({tag, "_hold_ovf"}, 32'(o), 32'(expo));
   endtask

   initial begin
      logic b, d, o;
      logic [15:0] dg;
      int n;
      bit drop;

      n_chk  = 0;
      n_fail = 0;

      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1234);
      drive(1'b1, 1'b1, 1234);
      repeat (3) @(posedge clk);
      #1;
      get(1'b0, b, d, o, dg);
      chk("rst_a_busy", 32'(b), 32'd0);
      chk("rst_a_done", 32'(d), 32'd0);
      chk("rst_a_ovf", 32'(o), 32'd0);
      chk("rst_a_dig", 32'(dg), 32'h0000);
      get(1'b1, b, d, o, dg);
      chk("rst_b_busy", 32'(b), 32'd0);
      chk("rst_b_dig", 32'(dg), 32'h0000);
      drive(1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      get(1'b0, b, d, o, dg);
      chk("idle_no_start", 32'(b), 32'd0);

      convert(1'b0, 1234, 16'h1234, 1'b0, "c1234");
      convert(1'b0, 12000, 16'h9999, 1'b1, "sat12000");
      convert(1'b0, 42, 16'h0042, 1'b0, "c42");
      convert(1'b0, 9999, 16'h9999, 1'b0, "c9999");
      convert(1'b0, 10000, 16'h9999, 1'b1, "sat10000");
      convert(1'b0, 16383, 16'h9999, 1'b1, "sat_max");
      convert(1'b0, 0, 16'h0000, 1'b0, "c0");
      convert(1'b0, 5678, 16'h5678, 1'b0, "c5678");

      convert(1'b1, 7, 16'hFFF7, 1'b0, "blk7");
      convert(1'b1, 0, 16'hFFF0, 1'b0, "blk0");
      convert(1'b1, 1005, 16'h1005, 1'b0, "blk1005");
      convert(1'b1, 40, 16'hFF40, 1'b0, "blk40");
      convert(1'b1, 100, 16'hF100, 1'b0, "blk100");

      drive(1'b0, 1'b1, 1234);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 4321);
      wait_done(1'b0, n, drop);
      get(1'b0, b, d, o, dg);
      chk("hs_latency", 32'(n), 32'd15);
      chk("hs_first_val", 32'(dg), 32'h1234);
      drive(1'b0, 1'b1, 9876);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 0);
      get(1'b0, b, d, o, dg);
      chk("hs_b2b_busy", 32'(b), 32'd1);
      wait_done(1'b0, n, drop);
      get(1'b0, b, d, o, dg);
      chk("hs_b2b_latency", 32'(n), 32'd15);
      chk("hs_b2b_dig", 32'(dg), 32'h9876);

      drive(1'b0, 1'b1, 5555);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 0);
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      get(1'b0, b, d, o, dg);
      chk("mid_rst_dig", 32'(dg), 32'h0000);
      chk("mid_rst_busy", 32'(b), 32'd0);
      chk("mid_rst_done", 32'(d), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      drop = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         get(1'b0, b, d, o, dg);
         if (d || b) drop = 1'b1;
      end
      chk("mid_rst_no_done", 32'(drop), 32'd0);
      convert(1'b0, 88, 16'h0088, 1'b0, "after_rst88");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
